// File: rtl/uop_pkg.sv
// Shared types and constants for the micro-op sequencer: FSM states, opcode
// classes, the opcode map and the per-(opcode, step) table entry format.
package uop_pkg;

  localparam int UOP_OPC_W     = 8;
  localparam int UOP_CTRL_W    = 16;
  localparam int UOP_STEP_W    = 2;
  localparam int COMMIT_BIT    = UOP_CTRL_W - 1;
  localparam int UOP_MAX_STEPS = 2;

  localparam logic [UOP_CTRL_W-1:0] UOP_NOP_CTRL = 16'h3000;

  localparam logic [UOP_OPC_W-1:0] LDI_BASE = 8'h00;
  localparam logic [UOP_OPC_W-1:0] REG_BASE = 8'h08;
  localparam logic [UOP_OPC_W-1:0] ALU_BASE = 8'h20;
  localparam logic [UOP_OPC_W-1:0] ALU_END  = 8'h7F;
  localparam logic [UOP_OPC_W-1:0] OPC_LDIP = 8'h80;
  localparam logic [UOP_OPC_W-1:0] OPC_HALT = 8'hFE;
  localparam logic [UOP_OPC_W-1:0] OPC_NOP  = 8'hFF;

  typedef enum logic [1:0] {IDLE, IMM, EXEC, HALT} state_t;

  typedef enum logic [2:0] {
    CLS_LDI, CLS_REG, CLS_ALU, CLS_LDIP, CLS_HALT, CLS_NOP, CLS_ILL
  } uop_class_t;

  typedef struct packed {
    logic [UOP_CTRL_W-1:0] ctrl;
    logic [UOP_STEP_W:0]   n_steps;
    logic                  needs_imm;
    logic                  legal;
  } uop_entry_t;

  function automatic uop_class_t opc_class(input logic [UOP_OPC_W-1:0] opc);
    if (opc < REG_BASE)      return CLS_LDI;
    else if (opc < ALU_BASE) return CLS_REG;
    else if (opc <= ALU_END) return CLS_ALU;
    else if (opc == OPC_LDIP) return CLS_LDIP;
    else if (opc == OPC_HALT) return CLS_HALT;
    else if (opc == OPC_NOP)  return CLS_NOP;
    else                      return CLS_ILL;
  endfunction

endpackage

// File: rtl/uop_rom.sv
// Combinational micro-op table: maps (opcode, step) to the control word and
// the instruction's step count, immediate requirement and legality.
module uop_rom
  import uop_pkg::*;
(
  input  logic [UOP_OPC_W-1:0]  opcode,
  input  logic [UOP_STEP_W-1:0] step,
  output uop_entry_t            entry
);

  if (UOP_MAX_STEPS > (1 << UOP_STEP_W)) begin : g_step_check
    $error("uop_rom: table entry needs more steps than the step counter can index");
  end

  logic [UOP_CTRL_W-1:0] alu_word;

  // ALU word: bit14/bit4 carry the mode bit, [10:8] the ALU group, [2:0] the
  // operand select; the writeback step adds COMMIT on top of the read word.
  always_comb begin
    alu_word        = 16'h3000;
    alu_word[14]    = opcode[3];
    alu_word[10:8]  = opcode[6:4] - 3'd1;
    alu_word[4]     = opcode[3];
    alu_word[2:0]   = opcode[2:0];
    if (step != '0) alu_word[COMMIT_BIT] = 1'b1;
  end

  always_comb begin
    entry.ctrl      = UOP_NOP_CTRL;
    entry.n_steps   = (UOP_STEP_W+1)'(1);
    entry.needs_imm = 1'b0;
    entry.legal     = 1'b1;
    case (opc_class(opcode))
      CLS_LDI: begin
        entry.ctrl      = 16'h6000 | {9'b0, opcode[2:0], 4'b0};
        entry.needs_imm = 1'b1;
      end
      CLS_REG:  entry.ctrl = 16'h4000 | {11'b0, opcode[4:0]};
      CLS_ALU: begin
        entry.ctrl    = alu_word;
        entry.n_steps = (UOP_STEP_W+1)'(2);
      end
      CLS_LDIP: begin
        entry.ctrl      = 16'h6080;
        entry.needs_imm = 1'b1;
      end
      CLS_HALT: entry.ctrl = 16'h2F00;
      CLS_NOP:  entry.ctrl = UOP_NOP_CTRL;
      default:  entry.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/uop_sequencer.sv
// Micro-op sequencer: accepts an opcode (and optional immediate) and emits its
// control-word sequence to the datapath under valid/ready back-pressure.
module uop_sequencer
  import uop_pkg::*;
#(
  parameter int                OPC_W    = 8,
  parameter int                CTRL_W   = 16,
  parameter int                STEP_W   = 2,
  parameter logic [CTRL_W-1:0] NOP_CTRL = 16'h3000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [OPC_W-1:0]  instr,
  output logic              instr_ready,
  input  logic              imm_valid,
  input  logic [OPC_W-1:0]  imm_data,
  output logic              imm_ready,
  output logic              ctrl_valid,
  input  logic              ctrl_ready,
  output logic [CTRL_W-1:0] ctrl_word,
  output logic [STEP_W-1:0] ctrl_step,
  output logic              ctrl_last,
  output logic [OPC_W-1:0]  ibuf,
  output logic [OPC_W-1:0]  imm_buf,
  output logic              illegal,
  output logic              halted
);

  if (OPC_W != UOP_OPC_W || CTRL_W != UOP_CTRL_W || STEP_W != UOP_STEP_W) begin : g_width_check
    $error("uop_sequencer: parameters do not match the micro-op table widths");
  end

  state_t            state, state_n;
  logic              ctrl_valid_n, ctrl_last_n, illegal_n, halted_n;
  logic              instr_ready_n, imm_ready_n;
  logic [CTRL_W-1:0] ctrl_word_n;
  logic [STEP_W-1:0] ctrl_step_n;
  logic [OPC_W-1:0]  ibuf_n, imm_buf_n;

  logic [OPC_W-1:0]  rom_opc;
  logic [STEP_W-1:0] rom_step;
  uop_entry_t        entry;
  logic              entry_last;

  // In IDLE the table is addressed by the incoming opcode so the first word
  // is ready the cycle after the handshake; otherwise by the latched one.
  assign rom_opc    = (state == IDLE) ? instr : ibuf;
  assign rom_step   = (state == EXEC) ? ctrl_step + STEP_W'(1) : '0;
  assign entry_last = ((STEP_W+1)'(rom_step) + (STEP_W+1)'(1)) == entry.n_steps;

  uop_rom u_rom (
    .opcode (rom_opc),
    .step   (rom_step),
    .entry  (entry)
  );

  always_comb begin
    state_n       = state;
    ctrl_valid_n  = ctrl_valid;
    ctrl_word_n   = ctrl_word;
    ctrl_step_n   = ctrl_step;
    ctrl_last_n   = ctrl_last;
    ibuf_n        = ibuf;
    imm_buf_n     = imm_buf;
    illegal_n     = illegal;
    halted_n      = halted;
    instr_ready_n = instr_ready;
    imm_ready_n   = imm_ready;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          ibuf_n        = instr;
          instr_ready_n = 1'b0;
          if (entry.needs_imm) begin
            state_n     = IMM;
            imm_ready_n = 1'b1;
          end else begin
            state_n      = EXEC;
            ctrl_valid_n = 1'b1;
            ctrl_word_n  = entry.ctrl;
            ctrl_step_n  = rom_step;
            ctrl_last_n  = entry_last;
            illegal_n    = ~entry.legal;
          end
        end
      end
      IMM: begin
        if (imm_valid) begin
          imm_buf_n    = imm_data;
          imm_ready_n  = 1'b0;
          state_n      = EXEC;
          ctrl_valid_n = 1'b1;
          ctrl_word_n  = entry.ctrl;
          ctrl_step_n  = rom_step;
          ctrl_last_n  = entry_last;
          illegal_n    = ~entry.legal;
        end
      end
      EXEC: begin
        if (ctrl_ready) begin
          if (ctrl_last) begin
            ctrl_valid_n = 1'b0;
            ctrl_last_n  = 1'b0;
            illegal_n    = 1'b0;
            if (opc_class(ibuf) == CLS_HALT) begin
              state_n  = HALT;
              halted_n = 1'b1;
            end else begin
              state_n       = IDLE;
              instr_ready_n = 1'b1;
            end
          end else begin
            ctrl_word_n = entry.ctrl;
            ctrl_step_n = rom_step;
            ctrl_last_n = entry_last;
          end
        end
      end
      default: begin
        instr_ready_n = 1'b0;
        imm_ready_n   = 1'b0;
        ctrl_valid_n  = 1'b0;
        halted_n      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ctrl_valid  <= 1'b0;
      ctrl_word   <= NOP_CTRL;
      ctrl_step   <= '0;
      ctrl_last   <= 1'b0;
      ibuf        <= '1;
      imm_buf     <= '0;
      illegal     <= 1'b0;
      halted      <= 1'b0;
      instr_ready <= 1'b1;
      imm_ready   <= 1'b0;
    end else begin
      state       <= state_n;
      ctrl_valid  <= ctrl_valid_n;
      ctrl_word   <= ctrl_word_n;
      ctrl_step   <= ctrl_step_n;
      ctrl_last   <= ctrl_last_n;
      ibuf        <= ibuf_n;
      imm_buf     <= imm_buf_n;
      illegal     <= illegal_n;
      halted      <= halted_n;
      instr_ready <= instr_ready_n;
      imm_ready   <= imm_ready_n;
    end
  end

endmodule

// File: tb/tb_uop_sequencer.sv
// Scoreboard bench for uop_sequencer: directed and random instructions whose
// expected control words come from an opcode-map model.
module tb_uop_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [7:0]  instr;
  logic        instr_ready;
  logic        imm_valid;
  logic [7:0]  imm_data;
  logic        imm_ready;
  logic        ctrl_valid;
  logic        ctrl_ready;
  logic [15:0] ctrl_word;
  logic [1:0]  ctrl_step;
  logic        ctrl_last;
  logic [7:0]  ibuf;
  logic [7:0]  imm_buf;
  logic        illegal;
  logic        halted;

  uop_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .imm_valid   (imm_valid),
    .imm_data    (imm_data),
    .imm_ready   (imm_ready),
    .ctrl_valid  (ctrl_valid),
    .ctrl_ready  (ctrl_ready),
    .ctrl_word   (ctrl_word),
    .ctrl_step   (ctrl_step),
    .ctrl_last   (ctrl_last),
    .ibuf        (ibuf),
    .imm_buf     (imm_buf),
    .illegal     (illegal),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    int          step;
    bit          last;
    bit          ill;
    logic [7:0]  opc;
    logic [7:0]  imm;
    bit          halt;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         ready_mode = 0;
  logic [7:0] model_imm = 8'h00;
  bit         pending_bubble = 0;
  bit         bubble_halt = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Opcode-map reference: step count, words, immediate need and legality.
  function automatic void model(input logic [7:0] opc, output int n, output logic [15:0] w0,
                                output logic [15:0] w1, output bit needs_imm, output bit legal);
    int o, hi, v;
    o = int'(opc);
    n = 1; w0 = 16'h3000; w1 = 16'h3000; needs_imm = 0; legal = 1;
    if (o <= 7) begin
      w0 = 16'(32'h6000 + o * 16); needs_imm = 1;
    end else if (o <= 'h1F) begin
      w0 = 16'(32'h4000 + o);
    end else if (o <= 'h7F) begin
      hi = (o / 8) % 2;
      v  = 'h3000 + hi * 'h4000 + (o / 16 - 1) * 'h100 + hi * 'h10 + o % 8;
      n  = 2; w0 = 16'(v); w1 = 16'(v + 'h8000);
    end else if (o == 'h80) begin
      w0 = 16'h6080; needs_imm = 1;
    end else if (o == 'hFE) begin
      w0 = 16'h2F00;
    end else if (o != 'hFF) begin
      legal = 0;
    end
  endfunction

  task automatic applyStimulus(input logic [7:0] opc, input logic [7:0] imm, input int imm_delay);
    int          n, t;
    logic [15:0] w0, w1;
    bit          needs_imm, legal;
    exp_t        e;
    model(opc, n, w0, w1, needs_imm, legal);
    t = 0;
    @(negedge clk);
    while (!instr_ready && t < 200) begin
      instr_valid = 1'($urandom_range(0, 1));
      instr       = 8'($urandom);
      imm_valid   = 1'($urandom_range(0, 1));
      imm_data    = 8'($urandom);
      @(negedge clk);
      t++;
    end
    if (!instr_ready) begin
      checkOutput("instr_ready_timeout", 32'(instr_ready), 1);
      instr_valid = 1'b0;
      imm_valid   = 1'b0;
      return;
    end
    if (needs_imm) model_imm = imm;
    for (int s = 0; s < n; s++) begin
      e.word = (s == 0) ? w0 : w1;
      e.step = s;
      e.last = (s == n - 1);
      e.ill  = !legal;
      e.opc  = opc;
      e.imm  = model_imm;
      e.halt = (opc == 8'hFE);
      exp_q.push_back(e);
    end
    instr_valid = 1'b1;
    instr       = opc;
    imm_valid   = needs_imm ? 1'b0 : 1'($urandom_range(0, 1));
    imm_data    = 8'($urandom);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    imm_valid   = 1'b0;
    if (needs_imm) begin
      for (int d = 0; d <= imm_delay; d++) begin
        @(negedge clk);
        checkOutput($sformatf("imm_ready op%02h", opc), 32'(imm_ready), 1);
        checkOutput($sformatf("imm_wait_valid op%02h", opc), 32'(ctrl_valid), 0);
        if (d == imm_delay) begin
          imm_valid = 1'b1;
          imm_data  = imm;
        end
      end
      @(posedge clk);
      #1;
      imm_valid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || pending_bubble) && t < 400) begin
      @(negedge clk);
      t++;
    end
    checkOutput("scoreboard_drain", 32'(exp_q.size()), 0);
    @(negedge clk);
  endtask

  // ctrl_ready changes just after each rising edge: random, forced high or forced low.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       ctrl_ready = 1'b1;
        2:       ctrl_ready = 1'b0;
        default: ctrl_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every accepted control word is popped from the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (pending_bubble) begin
          pending_bubble = 0;
          checkOutput("bubble_ctrl_valid", 32'(ctrl_valid), 0);
          checkOutput("bubble_instr_ready", 32'(instr_ready), 32'(!bubble_halt));
          checkOutput("bubble_halted", 32'(halted), 32'(bubble_halt));
        end
        if (ctrl_valid && ctrl_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_word", 32'(ctrl_valid), 0);
          end else begin
            e = exp_q.pop_front();
            checkOutput($sformatf("word op%02h s%0d", e.opc, e.step), 32'(ctrl_word), 32'(e.word));
            checkOutput($sformatf("step op%02h", e.opc), 32'(ctrl_step), 32'(e.step));
            checkOutput($sformatf("last op%02h s%0d", e.opc, e.step), 32'(ctrl_last), 32'(e.last));
            checkOutput($sformatf("illegal op%02h", e.opc), 32'(illegal), 32'(e.ill));
            checkOutput($sformatf("ibuf op%02h", e.opc), 32'(ibuf), 32'(e.opc));
            checkOutput($sformatf("imm_buf op%02h", e.opc), 32'(imm_buf), 32'(e.imm));
            if (e.last) begin
              pending_bubble = 1;
              bubble_halt    = e.halt;
            end
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] opc;
    rst_n       = 1'b0;
    instr_valid = 1'b1;
    instr       = 8'h21;
    imm_valid   = 1'b0;
    imm_data    = 8'h00;
    ctrl_ready  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ctrl_valid", 32'(ctrl_valid), 0);
    checkOutput("reset_ctrl_word", 32'(ctrl_word), 32'h3000);
    checkOutput("reset_ctrl_step", 32'(ctrl_step), 0);
    checkOutput("reset_ctrl_last", 32'(ctrl_last), 0);
    checkOutput("reset_ibuf", 32'(ibuf), 32'hFF);
    checkOutput("reset_imm_buf", 32'(imm_buf), 0);
    checkOutput("reset_illegal", 32'(illegal), 0);
    checkOutput("reset_halted", 32'(halted), 0);
    instr_valid = 1'b0;
    rst_n       = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_instr_ready", 32'(instr_ready), 1);
    checkOutput("post_reset_ctrl_valid", 32'(ctrl_valid), 0);
    checkOutput("post_reset_imm_ready", 32'(imm_ready), 0);

    ready_mode = 1;
    applyStimulus(8'h21, 8'h00, 0);
    applyStimulus(8'h03, 8'h5A, 3);
    waitDrain();

    ready_mode = 2;
    applyStimulus(8'h2A, 8'h00, 0);
    repeat (4) begin
      @(negedge clk);
      checkOutput("stall_ctrl_valid", 32'(ctrl_valid), 1);
      checkOutput("stall_ctrl_word", 32'(ctrl_word), 32'h7112);
      checkOutput("stall_ctrl_step", 32'(ctrl_step), 0);
    end
    ready_mode = 1;
    applyStimulus(8'h90, 8'h00, 0);
    applyStimulus(8'hFF, 8'h00, 0);
    waitDrain();

    ready_mode = 0;
    repeat (60) begin
      opc = 8'($urandom);
      if (opc == 8'hFE) opc = 8'hFF;
      if ($urandom_range(0, 3) == 0) opc = 8'($urandom_range(0, 7));
      applyStimulus(opc, 8'($urandom), int'($urandom_range(0, 3)));
    end
    waitDrain();

    ready_mode = 2;
    applyStimulus(8'h25, 8'h00, 0);
    @(negedge clk);
    checkOutput("pre_abort_ctrl_valid", 32'(ctrl_valid), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_ctrl_valid", 32'(ctrl_valid), 0);
    checkOutput("abort_ctrl_word", 32'(ctrl_word), 32'h3000);
    exp_q.delete();
    pending_bubble = 0;
    model_imm      = 8'h00;
    ready_mode     = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("abort_no_step1", 32'(ctrl_valid), 0);
    end

    applyStimulus(8'hFE, 8'h00, 0);
    waitDrain();
    repeat (10) begin
      instr_valid = 1'b1;
      instr       = 8'($urandom);
      imm_valid   = 1'b1;
      @(negedge clk);
      checkOutput("halt_halted", 32'(halted), 1);
      checkOutput("halt_instr_ready", 32'(instr_ready), 0);
      checkOutput("halt_imm_ready", 32'(imm_ready), 0);
      checkOutput("halt_ctrl_valid", 32'(ctrl_valid), 0);
    end
    instr_valid = 1'b0;
    imm_valid   = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
